// File: rtl/memwb_pipe_stage.sv
// MEM/WB pipeline stage: a main register that drives the writeback outputs
// plus one skid register, so ReadyM depends only on registered state.
// Optional feature: define MEMWB_RESULT_MUX_EN to add the ResultW output
// (writeback result mux of ReadDataW/ALUOutW).
module memwb_pipe_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              ValidM,
    output logic              ReadyM,
    input  logic [DATA_W-1:0] ReadDataM,
    input  logic [DATA_W-1:0] ALUOutM,
    input  logic [REG_W-1:0]  WriteRegM,
    input  logic              RegWriteM,
    input  logic              MemtoRegM,
    output logic              ValidW,
    input  logic              ReadyW,
    output logic [DATA_W-1:0] ReadDataW,
    output logic [DATA_W-1:0] ALUOutW,
    output logic [REG_W-1:0]  WriteRegW,
    output logic              MemtoRegW,
    output logic              RegWriteW,
    output logic [CNT_W-1:0]  StallCnt
`ifdef MEMWB_RESULT_MUX_EN
    ,
    output logic [DATA_W-1:0] ResultW
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    logic              main_regwrite;
    logic [DATA_W-1:0] skid_readdata;
    logic [DATA_W-1:0] skid_aluout;
    logic [REG_W-1:0]  skid_writereg;
    logic              skid_regwrite;
    logic              skid_memtoreg;

    // Handshake outputs are pure decodes of the registered state.
    assign ReadyM    = (state != FULL);
    assign ValidW    = (state != EMPTY);
    assign RegWriteW = main_regwrite & ValidW;

`ifdef MEMWB_RESULT_MUX_EN
    assign ResultW = MemtoRegW ? ReadDataW : ALUOutW;
`endif

    // State register; reset has priority over everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and register load selection; flush drops everything.
    always_comb begin
        next_state     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (ValidM) begin
                    load_main_in = 1'b1;
                    next_state   = BUSY;
                end
            end
            BUSY: begin
                if (ValidM && ReadyW) begin
                    load_main_in = 1'b1;
                end else if (ValidM && !ReadyW) begin
                    load_skid  = 1'b1;
                    next_state = FULL;
                end else if (!ValidM && ReadyW) begin
                    next_state = EMPTY;
                end
            end
            FULL: begin
                if (ReadyW) begin
                    load_main_skid = 1'b1;
                    next_state     = BUSY;
                end
            end
            default: begin
                next_state = EMPTY;
            end
        endcase
        if (flush) begin
            next_state     = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // Main register: loads from the upstream word or from the skid entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            ReadDataW     <= '0;
            ALUOutW       <= '0;
            WriteRegW     <= '0;
            main_regwrite <= 1'b0;
            MemtoRegW     <= 1'b0;
        end else if (load_main_in) begin
            ReadDataW     <= ReadDataM;
            ALUOutW       <= ALUOutM;
            WriteRegW     <= WriteRegM;
            main_regwrite <= RegWriteM;
            MemtoRegW     <= MemtoRegM;
        end else if (load_main_skid) begin
            ReadDataW     <= skid_readdata;
            ALUOutW       <= skid_aluout;
            WriteRegW     <= skid_writereg;
            main_regwrite <= skid_regwrite;
            MemtoRegW     <= skid_memtoreg;
        end
    end

    // Skid register captures the word accepted while downstream stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            skid_readdata <= '0;
            skid_aluout   <= '0;
            skid_writereg <= '0;
            skid_regwrite <= 1'b0;
            skid_memtoreg <= 1'b0;
        end else if (load_skid) begin
            skid_readdata <= ReadDataM;
            skid_aluout   <= ALUOutM;
            skid_writereg <= WriteRegM;
            skid_regwrite <= RegWriteM;
            skid_memtoreg <= MemtoRegM;
        end
    end

    // Saturating count of cycles where upstream offers a word but is refused.
    always_ff @(posedge clk) begin
        if (reset) begin
            StallCnt <= '0;
        end else if (ValidM && !ReadyM && (StallCnt != {CNT_W{1'b1}})) begin
            StallCnt <= StallCnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_memwb_pipe_stage.sv
// Testbench for memwb_pipe_stage: directed scenarios plus randomized traffic,
// compared every cycle against a two-entry FIFO reference model.
module tb_memwb_pipe_stage;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef logic [70:0] word_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              flush = 1'b0;
    logic              ValidM = 1'b0;
    logic              ReadyM;
    logic [DATA_W-1:0] ReadDataM = '0;
    logic [DATA_W-1:0] ALUOutM = '0;
    logic [REG_W-1:0]  WriteRegM = '0;
    logic              RegWriteM = 1'b0;
    logic              MemtoRegM = 1'b0;
    logic              ValidW;
    logic              ReadyW = 1'b0;
    logic [DATA_W-1:0] ReadDataW;
    logic [DATA_W-1:0] ALUOutW;
    logic [REG_W-1:0]  WriteRegW;
    logic              MemtoRegW;
    logic              RegWriteW;
    logic [CNT_W-1:0]  StallCnt;
`ifdef MEMWB_RESULT_MUX_EN
    logic [DATA_W-1:0] ResultW;
`endif

    int total = 0;
    int bad = 0;

    word_t q[$];
    word_t lastOut = '0;
    int    stallModel = 0;

    memwb_pipe_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .ValidM(ValidM), .ReadyM(ReadyM),
        .ReadDataM(ReadDataM), .ALUOutM(ALUOutM), .WriteRegM(WriteRegM),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .ValidW(ValidW), .ReadyW(ReadyW),
        .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WriteRegW(WriteRegW),
        .MemtoRegW(MemtoRegW), .RegWriteW(RegWriteW), .StallCnt(StallCnt)
`ifdef MEMWB_RESULT_MUX_EN
        , .ResultW(ResultW)
`endif
    );

    always #5 clk = ~clk;

    function automatic word_t mk(input logic [31:0] rd, input logic [31:0] alu,
                                 input logic [4:0] wreg, input logic rw, input logic m2r);
        return {rd, alu, wreg, rw, m2r};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: stage behaves as a two-deep FIFO whose head is shown on W.
    task automatic checkAll();
        logic validExp;
        validExp = (q.size() > 0);
        checkOutput("ReadyM", ReadyM, q.size() < 2);
        checkOutput("ValidW", ValidW, validExp);
        checkOutput("ReadDataW", ReadDataW, lastOut[70:39]);
        checkOutput("ALUOutW", ALUOutW, lastOut[38:7]);
        checkOutput("WriteRegW", WriteRegW, lastOut[6:2]);
        checkOutput("MemtoRegW", MemtoRegW, lastOut[0]);
        checkOutput("RegWriteW", RegWriteW, lastOut[1] & validExp);
        checkOutput("StallCnt", StallCnt, stallModel);
`ifdef MEMWB_RESULT_MUX_EN
        checkOutput("ResultW", ResultW, lastOut[0] ? lastOut[70:39] : lastOut[38:7]);
`endif
    endtask

    task automatic modelUpdate();
        logic doPop;
        logic doPush;
        if (reset) begin
            q.delete();
            lastOut = '0;
            stallModel = 0;
        end else begin
            if (ValidM && q.size() == 2 && stallModel < CNT_MAX) stallModel++;
            if (flush) begin
                q.delete();
            end else begin
                doPop  = (q.size() > 0) && ReadyW;
                doPush = ValidM && (q.size() < 2);
                if (doPop) void'(q.pop_front());
                if (doPush) q.push_back({ReadDataM, ALUOutM, WriteRegM, RegWriteM, MemtoRegM});
            end
            if (q.size() > 0) lastOut = q[0];
        end
    endtask

    task automatic step();
        @(negedge clk);
        checkAll();
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic rdy, input logic fl,
                                 input logic rs, input word_t w);
        ValidM    = v;
        ReadyW    = rdy;
        flush     = fl;
        reset     = rs;
        ReadDataM = w[70:39];
        ALUOutM   = w[38:7];
        WriteRegM = w[6:2];
        RegWriteM = w[1];
        MemtoRegM = w[0];
        step();
    endtask

    task automatic doReset();
        reset  = 1'b1;
        flush  = 1'b0;
        ValidM = 1'b0;
        ReadyW = 1'b0;
        @(posedge clk);
        q.delete();
        lastOut = '0;
        stallModel = 0;
        #1;
        reset = 1'b0;
        checkOutput("rst_ReadyM", ReadyM, 1);
        checkOutput("rst_ValidW", ValidW, 0);
        checkOutput("rst_StallCnt", StallCnt, 0);
        checkOutput("rst_ALUOutW", ALUOutW, 0);
        checkOutput("rst_RegWriteW", RegWriteW, 0);
    endtask

    initial begin
        word_t w;
        $display("[TB] starting memwb_pipe_stage bench");

        // Single word through an empty stage, one-cycle latency.
        doReset();
        applyStimulus(1, 1, 0, 0, mk(32'h0, 32'h10, 5'd5, 1'b1, 1'b0));
        checkOutput("lat_ValidW", ValidW, 1);
        checkOutput("lat_ALUOutW", ALUOutW, 32'h10);
        checkOutput("lat_WriteRegW", WriteRegW, 5);
        checkOutput("lat_RegWriteW", RegWriteW, 1);
        applyStimulus(0, 1, 0, 0, '0);

        // Back-pressure: A held, B in skid, C refused, then drained in order.
        doReset();
        applyStimulus(1, 1, 0, 0, mk(32'h0, 32'hA, 5'd1, 1'b1, 1'b0));
        applyStimulus(1, 0, 0, 0, mk(32'h0, 32'hB, 5'd2, 1'b1, 1'b0));
        checkOutput("bp_ReadyM", ReadyM, 0);
        checkOutput("bp_head", ALUOutW, 32'hA);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, mk(32'h0, 32'hC, 5'd3, 1'b1, 1'b0));
        checkOutput("bp_StallCnt", StallCnt, 3);
        applyStimulus(1, 1, 0, 0, mk(32'h0, 32'hC, 5'd3, 1'b1, 1'b0));
        checkOutput("bp_second", ALUOutW, 32'hB);
        applyStimulus(1, 1, 0, 0, mk(32'h0, 32'hC, 5'd3, 1'b1, 1'b0));
        checkOutput("bp_third", ALUOutW, 32'hC);
        applyStimulus(0, 1, 0, 0, '0);
        applyStimulus(0, 1, 0, 0, '0);

        // Flush while FULL discards both held words and the incoming one.
        doReset();
        applyStimulus(1, 1, 0, 0, mk(32'h1, 32'hA, 5'd1, 1'b1, 1'b0));
        applyStimulus(1, 0, 0, 0, mk(32'h2, 32'hB, 5'd2, 1'b1, 1'b0));
        applyStimulus(1, 0, 1, 0, mk(32'h3, 32'hD, 5'd4, 1'b1, 1'b0));
        checkOutput("fl_ValidW", ValidW, 0);
        checkOutput("fl_RegWriteW", RegWriteW, 0);
        checkOutput("fl_ReadyM", ReadyM, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, '0);

        // Reset together with flush while BUSY.
        applyStimulus(1, 1, 0, 0, mk(32'h77, 32'h88, 5'd9, 1'b1, 1'b1));
        applyStimulus(0, 0, 1, 1, '0);
        checkOutput("rf_ValidW", ValidW, 0);
        checkOutput("rf_ReadDataW", ReadDataW, 0);
        checkOutput("rf_ALUOutW", ALUOutW, 0);
        checkOutput("rf_WriteRegW", WriteRegW, 0);
        checkOutput("rf_StallCnt", StallCnt, 0);
        reset = 1'b0;
        flush = 1'b0;

`ifdef MEMWB_RESULT_MUX_EN
        // Result mux selects memory data or ALU result.
        applyStimulus(1, 1, 0, 0, mk(32'h55, 32'h66, 5'd7, 1'b1, 1'b1));
        checkOutput("mux_mem", ResultW, 32'h55);
        applyStimulus(1, 1, 0, 0, mk(32'h55, 32'h66, 5'd7, 1'b1, 1'b0));
        checkOutput("mux_alu", ResultW, 32'h66);
        applyStimulus(0, 1, 0, 0, '0);
`endif

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 2000; i++) begin
            w = mk($urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom));
            applyStimulus(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
                          ($urandom_range(0, 29) == 0), ($urandom_range(0, 99) == 0), w);
        end
        reset = 1'b0;
        flush = 1'b0;

        // Long stall to saturate the counter.
        doReset();
        ValidM = 1'b1;
        ReadyW = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        checkOutput("sat_StallCnt", StallCnt, 16'hFFFF);
        checkOutput("sat_ReadyM", ReadyM, 0);
        checkOutput("sat_ValidW", ValidW, 1);
        doReset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memwb_pipe_stage.md
MEMWB_PIPE_STAGE -- requirements
Module: memwb_pipe_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of ReadData/ALUOut fields.
REQ-002 SHALL have parameter REG_W, default 5, width of WriteReg field.
REQ-003 SHALL have parameter CNT_W, default 16, width of stall counter.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  synchronous flush; drops all held and incoming entries.
REQ-007 SHALL have ports ValidM input 1 / ReadyM output 1  upstream handshake.
REQ-008 SHALL have ports ReadDataM, ALUOutM  input  DATA_W  memory-stage results.
REQ-009 SHALL have ports WriteRegM input REG_W / RegWriteM input 1 / MemtoRegM input 1  writeback control.
REQ-010 SHALL have ports ValidW output 1 / ReadyW input 1  downstream handshake.
REQ-011 SHALL have ports ReadDataW, ALUOutW output DATA_W; WriteRegW output REG_W; MemtoRegW output 1.
REQ-012 SHALL have port RegWriteW  output  1  stored RegWrite AND ValidW (qualified write enable).
REQ-013 SHALL have port StallCnt  output  CNT_W  saturating count of upstream back-pressure cycles.

Function
REQ-014 SHALL hold a main register (drives W outputs) and one skid register; states EMPTY, BUSY (main valid), FULL (main+skid valid).
REQ-015 SHALL drive ReadyM = 1 in EMPTY and BUSY, 0 in FULL; ReadyM SHALL be a registered-state decode, never combinationally dependent on ReadyW.
REQ-016 SHALL drive ValidW = 1 in BUSY and FULL, 0 in EMPTY.
REQ-017 EMPTY: ValidM=1 -> main<=inputs, go BUSY; else stay.
REQ-018 BUSY: ValidM&ReadyW -> main<=inputs, stay; ValidM&!ReadyW -> skid<=inputs, go FULL; !ValidM&ReadyW -> EMPTY; neither -> stay.
REQ-019 FULL: ReadyW=1 -> main<=skid, go BUSY; ReadyW=0 -> stay; ValidM ignored.
REQ-020 SHALL give 1-cycle latency: word accepted at edge N appears on W outputs after edge N when main was free or draining.
REQ-021 SHALL preserve order and never drop or duplicate a word absent flush/reset.
REQ-022 flush=1 SHALL force EMPTY at next edge, discarding main, skid and any word presented that cycle; flush overrides all transitions.
REQ-023 Payload outputs SHALL hold last value when ValidW=0; only ValidW/RegWriteW indicate validity.
REQ-024 StallCnt SHALL increment each cycle ValidM=1 and ReadyM=0, saturate at 2^CNT_W-1, unaffected by flush.

Reset
REQ-025 reset=1 at an edge SHALL set state EMPTY and zero ReadDataW, ALUOutW, WriteRegW, MemtoRegW, RegWriteW, skid contents and StallCnt; reset overrides flush and handshakes.
REQ-026 After reset: ReadyM=1, ValidW=0 in the first cycle; reset mid-operation SHALL discard held words.

Configuration
REQ-027 With macro MEMWB_RESULT_MUX_EN defined, SHALL add output ResultW (DATA_W) = MemtoRegW ? ReadDataW : ALUOutW, combinational from main register, 0 after reset.
REQ-028 Without MEMWB_RESULT_MUX_EN, ResultW SHALL not exist and all other behaviour SHALL be identical.

Verification
REQ-029 Reset then ValidM=1, ALUOutM=0x00000010, WriteRegM=5, RegWriteM=1, ReadyW=1 -> next cycle ValidW=1, ALUOutW=0x10, WriteRegW=5, RegWriteW=1.
REQ-030 Stream 0xA,0xB,0xC with ReadyW=0 from cycle 2 -> A held, B in skid, ReadyM=0, StallCnt=1 per stalled cycle; ReadyW=1 -> A,B,C out in order, no loss.
REQ-031 FULL state, flush=1 with ValidM=1 data 0xD -> next cycle ValidW=0, RegWriteW=0, ReadyM=1; 0xD never appears.
REQ-032 Hold ValidM=1, ReadyW=0 for 70000 cycles with CNT_W=16 -> StallCnt saturates at 0xFFFF.
REQ-033 reset and flush both 1 while BUSY -> outputs zero, StallCnt=0, state EMPTY.
REQ-034 With MEMWB_RESULT_MUX_EN: ReadDataM=0x55, ALUOutM=0x66, MemtoRegM=1 then 0 -> ResultW=0x55 then 0x66.
